// File: rtl/uart_pkg.sv
// Shared UART definitions (FSM encodings, default bit period) for the transmitter and receiver.
// Optional even parity is built in when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 10;
  localparam int UART_CNT_W        = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_e;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts enabled cycles, clears on request, flags the last cycle of a bit.
// tick_next_o tells the owner whether the following cycle will be the last one.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o,
  output logic tick_next_o
);

  localparam logic [UART_CNT_W-1:0] LAST = UART_CNT_W'(CLKS_PER_BIT - 1);

  logic [UART_CNT_W-1:0] cnt_q;
  logic [UART_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o      = en_i && (cnt_q == LAST);
  assign tick_next_o = (cnt_d == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8N1) with a one-byte holding register for back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic [2:0]  bit_idx_q;
  logic        serial_q;
  logic        active_q;
  logic        done_q;

  logic tick;
  logic tick_next;
  logic accept;
  logic cnt_en;
  logic cnt_clr;
  logic stop_end;

  assign accept   = i_Tx_DV && !hold_full_q;
  assign cnt_en   = (state_q != IDLE);
  assign cnt_clr  = !cnt_en || tick;
  assign stop_end = (state_q == STOP) && tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk_i      (i_Clock),
    .rst_i      (i_Reset),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .tick_o     (tick),
    .tick_next_o(tick_next)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A byte arriving in the last stop cycle with nothing queued bypasses the holding register.
      if (accept && (state_q != IDLE) && !stop_end) begin
        hold_q      <= i_Tx_Byte;
        hold_full_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q  <= i_Tx_Byte;
            state_q  <= START;
            serial_q <= 1'b0;
            active_q <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state_q   <= DATA;
            serial_q  <= shift_q[0];
            bit_idx_q <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= PARITY;
              serial_q <= even_parity(shift_q);
`else
              state_q  <= STOP;
              serial_q <= 1'b1;
              done_q   <= tick_next;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q  <= STOP;
            serial_q <= 1'b1;
            done_q   <= tick_next;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              state_q     <= START;
              serial_q    <= 1'b0;
            end else if (accept) begin
              shift_q  <= i_Tx_Byte;
              state_q  <= START;
              serial_q <= 1'b0;
            end else begin
              state_q  <= IDLE;
              serial_q <= 1'b1;
              active_q <= 1'b0;
            end
          end else begin
            done_q <= tick_next;
          end
        end
        default: begin
          state_q  <= IDLE;
          serial_q <= 1'b1;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Tx_Ready  = !hold_full_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule
